// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined floating-point multiplier, RNE rounding, DAZ/FTZ
module fp_mult_pipe #(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int LATENCY = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   in_valid,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   sign,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   nan
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = W + 4;
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [MAN_W-1:0]      QNAN_F   = MAN_W'(1) << (MAN_W - 1);
  localparam logic signed [EW2-1:0] BIAS     = EW2'(2**(EXP_W-1) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'(2**EXP_W - 1);
  localparam logic signed [EW2-1:0] ONE      = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO     = '0;

  logic                 s1_sa_d, s1_sb_d, s1_za_d, s1_zb_d, s1_ia_d, s1_ib_d, s1_na_d, s1_nb_d;
  logic [EXP_W-1:0]     s1_ea_d, s1_eb_d;
  logic [MAN_W:0]       s1_ma_d, s1_mb_d;
  logic                 s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q, s1_ia_q, s1_ib_q, s1_na_q, s1_nb_q;
  logic [EXP_W-1:0]     s1_ea_q, s1_eb_q;
  logic [MAN_W:0]       s1_ma_q, s1_mb_q;

  logic                 s2_sign_d, s2_nan_d, s2_inf_d, s2_zero_d;
  logic signed [EW2-1:0] s2_exp_d;
  logic [2*MAN_W+1:0]   s2_prod_d;
  logic                 s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic signed [EW2-1:0] s2_exp_q;
  logic [2*MAN_W+1:0]   s2_prod_q;

  logic [MAN_W:0]       mant_n;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic                 guard, sticky;
  logic signed [EW2-1:0] exp_n, exp_r;
  logic [W-1:0]         s3_res_d;
  logic                 s3_ovf_d, s3_unf_d, s3_zero_d, s3_nan_d;
  logic [PW-1:0]        s3_pd_d;

  logic [PW-1:0]        pd_q [3:LATENCY];
  logic [LATENCY:1]     vld_q;

  // Subnormal operands collapse into the zero class (DAZ).
  always_comb begin
    s1_sa_d = dataa[W-1];
    s1_sb_d = datab[W-1];
    s1_ea_d = dataa[W-2:MAN_W];
    s1_eb_d = datab[W-2:MAN_W];
    s1_ma_d = {1'b1, dataa[MAN_W-1:0]};
    s1_mb_d = {1'b1, datab[MAN_W-1:0]};
    s1_za_d = (s1_ea_d == '0);
    s1_zb_d = (s1_eb_d == '0);
    s1_ia_d = (s1_ea_d == EXP_ONES) && (dataa[MAN_W-1:0] == '0);
    s1_ib_d = (s1_eb_d == EXP_ONES) && (datab[MAN_W-1:0] == '0);
    s1_na_d = (s1_ea_d == EXP_ONES) && (dataa[MAN_W-1:0] != '0);
    s1_nb_d = (s1_eb_d == EXP_ONES) && (datab[MAN_W-1:0] != '0);
  end

  always_comb begin
    s2_sign_d = s1_sa_q ^ s1_sb_q;
    s2_exp_d  = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - BIAS;
    s2_prod_d = (2*MAN_W+2)'(s1_ma_q) * (2*MAN_W+2)'(s1_mb_q);
    s2_nan_d  = s1_na_q | s1_nb_q | (s1_ia_q & s1_zb_q) | (s1_ib_q & s1_za_q);
    s2_inf_d  = s1_ia_q | s1_ib_q;
    s2_zero_d = s1_za_q | s1_zb_q;
  end

  always_comb begin
    if (s2_prod_q[2*MAN_W+1]) begin
      mant_n = s2_prod_q[2*MAN_W+1:MAN_W+1];
      guard  = s2_prod_q[MAN_W];
      sticky = |s2_prod_q[MAN_W-1:0];
      exp_n  = s2_exp_q + ONE;
    end else begin
      mant_n = s2_prod_q[2*MAN_W:MAN_W];
      guard  = s2_prod_q[MAN_W-1];
      sticky = |s2_prod_q[MAN_W-2:0];
      exp_n  = s2_exp_q;
    end
    mant_r = {1'b0, mant_n} + (MAN_W+2)'(guard & (sticky | mant_n[0]));
    // A rounding carry-out leaves 10.00..0, so the fraction becomes zero.
    if (mant_r[MAN_W+1]) begin
      frac_r = mant_r[MAN_W:1];
      exp_r  = exp_n + ONE;
    end else begin
      frac_r = mant_r[MAN_W-1:0];
      exp_r  = exp_n;
    end
    s3_ovf_d  = 1'b0;
    s3_unf_d  = 1'b0;
    s3_zero_d = 1'b0;
    s3_nan_d  = 1'b0;
    s3_res_d  = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
    if (s2_nan_q) begin
      s3_nan_d = 1'b1;
      s3_res_d = {1'b0, EXP_ONES, QNAN_F};
    end else if (s2_inf_q) begin
      s3_res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_zero_q) begin
      s3_zero_d = 1'b1;
      s3_res_d  = {s2_sign_q, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      s3_ovf_d = 1'b1;
      s3_res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (exp_r <= ZERO) begin
      s3_unf_d  = 1'b1;
      s3_zero_d = 1'b1;
      s3_res_d  = {s2_sign_q, {(W-1){1'b0}}};
    end
    s3_pd_d = {s3_res_d, s3_ovf_d, s3_unf_d, s3_zero_d, s3_nan_d};
  end

  // Data registers load only behind a valid, so outputs keep the last valid result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q, s1_ia_q, s1_ib_q, s1_na_q, s1_nb_q} <= '0;
      {s1_ea_q, s1_eb_q, s1_ma_q, s1_mb_q} <= '0;
      {s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q} <= '0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      for (int i = 3; i <= LATENCY; i++) pd_q[i] <= '0;
      vld_q <= '0;
    end else if (clk_en) begin
      vld_q <= {vld_q[LATENCY-1:1], in_valid};
      if (in_valid) begin
        {s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q} <= {s1_sa_d, s1_sb_d, s1_za_d, s1_zb_d};
        {s1_ia_q, s1_ib_q, s1_na_q, s1_nb_q} <= {s1_ia_d, s1_ib_d, s1_na_d, s1_nb_d};
        {s1_ea_q, s1_eb_q, s1_ma_q, s1_mb_q} <= {s1_ea_d, s1_eb_d, s1_ma_d, s1_mb_d};
      end
      if (vld_q[1]) begin
        {s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q} <= {s2_sign_d, s2_nan_d, s2_inf_d, s2_zero_d};
        s2_exp_q  <= s2_exp_d;
        s2_prod_q <= s2_prod_d;
      end
      if (vld_q[2]) pd_q[3] <= s3_pd_d;
      for (int i = 4; i <= LATENCY; i++) begin
        if (vld_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY];
  assign result    = pd_q[LATENCY][PW-1:4];
  assign overflow  = pd_q[LATENCY][3];
  assign underflow = pd_q[LATENCY][2];
  assign zero      = pd_q[LATENCY][1];
  assign nan       = pd_q[LATENCY][0];
  assign sign      = pd_q[LATENCY][PW-1];
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - directed-vector bench for fp_mult_pipe (half and single precision)
module tb_fp_mult_pipe;
  logic        clock = 1'b0;
  logic        reset_n, clk_en, in_valid, clk_en2, in_valid2;
  logic [15:0] dataa, datab, result;
  logic [31:0] dataa2, datab2, result2;
  logic        out_valid, sign, overflow, underflow, zero, nan;
  logic        out_valid2, sign2, overflow2, underflow2, zero2, nan2;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .LATENCY(8)) dut (
    .clock(clock), .reset_n(reset_n), .clk_en(clk_en), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .out_valid(out_valid), .result(result),
    .sign(sign), .overflow(overflow), .underflow(underflow), .zero(zero), .nan(nan));

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(3)) dut_sp (
    .clock(clock), .reset_n(reset_n), .clk_en(clk_en2), .in_valid(in_valid2),
    .dataa(dataa2), .datab(datab2), .out_valid(out_valid2), .result(result2),
    .sign(sign2), .overflow(overflow2), .underflow(underflow2), .zero(zero2), .nan(nan2));

  localparam logic [15:0] DA [11] = '{16'h3C00, 16'hC000, 16'h3C01, 16'h3C01, 16'h7BFF, 16'h0400,
                                      16'h7C00, 16'h7E00, 16'h0001, 16'h7C00, 16'h8000};
  localparam logic [15:0] DB [11] = '{16'h4000, 16'h3C00, 16'h3E00, 16'h3C01, 16'h4000, 16'h0400,
                                      16'h0000, 16'h3C00, 16'h3C00, 16'hC000, 16'h3C00};
  localparam logic [15:0] DR [11] = '{16'h4000, 16'hC000, 16'h3E02, 16'h3C02, 16'h7C00, 16'h0000,
                                      16'h7E00, 16'h7E00, 16'h0000, 16'hFC00, 16'h8000};
  // {overflow, underflow, zero, nan}
  localparam logic [3:0]  DF [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0110,
                                      4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0010};
  localparam logic [31:0] SA [3] = '{32'h3F800000, 32'h3FC00000, 32'h7F800000};
  localparam logic [31:0] SB [3] = '{32'h40000000, 32'h3FC00000, 32'h00000000};
  localparam logic [31:0] SR [3] = '{32'h40000000, 32'h40100000, 32'h7FC00000};
  localparam logic [3:0]  SF [3] = '{4'b0000, 4'b0000, 4'b0001};

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b1; in_valid = 1'b1; dataa = 16'h3C00; datab = 16'h4000;
    clk_en2 = 1'b1; in_valid2 = 1'b1; dataa2 = 32'h3F800000; datab2 = 32'h40000000;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({out_valid, result, sign, overflow, underflow, zero, nan} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_hp: got %h want 0", {out_valid, result, sign, overflow, underflow, zero, nan});
    end
    n_vec++;
    if ({out_valid2, result2, sign2, overflow2, underflow2, zero2, nan2} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_sp: got %h want 0", {out_valid2, result2, sign2, overflow2, underflow2, zero2, nan2});
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    n_vec++;
    if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: out_valid %b/%b want 0/0", out_valid, out_valid2);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 11; i++) begin
      int          lat;
      logic [15:0] er;
      logic [3:0]  ef;
      er = DR[i];
      ef = DF[i];
      @(negedge clock);
      in_valid = 1'b1; dataa = DA[i]; datab = DB[i];
      @(negedge clock);
      in_valid = 1'b0; dataa = 16'h0000; datab = 16'h0000;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      n_vec++;
      if (lat != 8) begin
        n_err++;
        $display("FAIL latency_%0d: got %0d cycles want 8", i, lat);
      end
      n_vec++;
      if ({result, overflow, underflow, zero, nan, sign} !== {er, ef, er[15]}) begin
        n_err++;
        $display("FAIL mult_%0d %h*%h: got res=%h flags=%b sign=%b want res=%h flags=%b sign=%b",
                 i, DA[i], DB[i], result, {overflow, underflow, zero, nan}, sign, er, ef, er[15]);
      end
      @(negedge clock);
      n_vec++;
      if (out_valid !== 1'b0 || result !== er || {overflow, underflow, zero, nan} !== ef) begin
        n_err++;
        $display("FAIL hold_%0d: got valid=%b res=%h want valid=0 res=%h", i, out_valid, result, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [20];
    logic [21:0] snap;
    int          sent, got, s0, s1, s2;
    logic        en, en_prev;
    for (int i = 0; i < 20; i++) exp_q[i] = (16'h3C00 + 16'(i * 3) + 16'h0400) | ((i % 2 == 1) ? 16'h8000 : 16'h0000);
    s0 = $urandom_range(9, 12);
    s1 = $urandom_range(13, 17);
    s2 = $urandom_range(18, 24);
    sent = 0; got = 0; en_prev = 1'b1; snap = '0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clock);
      if (cyc > 0) begin
        if (!en_prev) begin
          n_vec++;
          if ({out_valid, result, sign, overflow, underflow, zero, nan} !== snap) begin
            n_err++;
            $display("FAIL freeze_c%0d: got %h want %h", cyc,
                     {out_valid, result, sign, overflow, underflow, zero, nan}, snap);
          end
        end else if (out_valid === 1'b1) begin
          n_vec++;
          if (got >= 20) begin
            n_err++;
            $display("FAIL b2b_extra: got res=%h want no output", result);
          end else if (result !== exp_q[got] || {overflow, underflow, zero, nan} !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_%0d: got res=%h flags=%b want res=%h flags=0000", got, result,
                     {overflow, underflow, zero, nan}, exp_q[got]);
          end
          got++;
        end
      end
      snap = {out_valid, result, sign, overflow, underflow, zero, nan};
      en = !(cyc == s0 || cyc == s1 || cyc == s2);
      clk_en = en;
      en_prev = en;
      if (!en) begin
        in_valid = 1'b1; dataa = 16'h7E00; datab = 16'h7E00;
      end else if (sent < 20) begin
        in_valid = 1'b1;
        dataa = 16'h3C00 + 16'(sent * 3);
        datab = (sent % 2 == 1) ? 16'hC000 : 16'h4000;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    clk_en = 1'b1; in_valid = 1'b0;
    n_vec++;
    if (got != 20) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results want 20", got);
    end
  endtask

  task automatic test_wide();
    for (int i = 0; i < 3; i++) begin
      int          lat;
      logic [31:0] er;
      logic [3:0]  ef;
      er = SR[i];
      ef = SF[i];
      @(negedge clock);
      in_valid2 = 1'b1; dataa2 = SA[i]; datab2 = SB[i];
      @(negedge clock);
      in_valid2 = 1'b0;
      lat = 1;
      while (out_valid2 !== 1'b1 && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      n_vec++;
      if (lat != 3) begin
        n_err++;
        $display("FAIL sp_latency_%0d: got %0d cycles want 3", i, lat);
      end
      n_vec++;
      if ({result2, overflow2, underflow2, zero2, nan2, sign2} !== {er, ef, er[31]}) begin
        n_err++;
        $display("FAIL sp_mult_%0d: got res=%h flags=%b want res=%h flags=%b", i, result2,
                 {overflow2, underflow2, zero2, nan2}, er, ef);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid = 1'b1; dataa = 16'h3C01; datab = 16'h3C01;
      in_valid2 = 1'b1; dataa2 = 32'h3FC00000; datab2 = 32'h3FC00000;
    end
    @(negedge clock);
    in_valid = 1'b0; in_valid2 = 1'b0;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, result, sign, overflow, underflow, zero, nan} !== 22'd0) begin
      n_err++;
      $display("FAIL rst_async_hp: got %h want 0", {out_valid, result, sign, overflow, underflow, zero, nan});
    end
    n_vec++;
    if ({out_valid2, result2, sign2, overflow2, underflow2, zero2, nan2} !== 38'd0) begin
      n_err++;
      $display("FAIL rst_async_sp: got %h want 0", {out_valid2, result2, sign2, overflow2, underflow2, zero2, nan2});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      n_vec++;
      if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
        n_err++;
        $display("FAIL rst_flush_c%0d: out_valid %b/%b want 0/0", c, out_valid, out_valid2);
      end
    end
    in_valid = 1'b1; dataa = 16'h3C00; datab = 16'h4000;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    n_vec++;
    if (lat != 8 || result !== 16'h4000) begin
      n_err++;
      $display("FAIL rst_recover: got lat=%0d res=%h want lat=8 res=4000", lat, result);
    end
    in_valid2 = 1'b1; dataa2 = 32'h3F800000; datab2 = 32'h40000000;
    @(negedge clock);
    in_valid2 = 1'b0;
    lat = 1;
    while (out_valid2 !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    n_vec++;
    if (lat != 3 || result2 !== 32'h40000000) begin
      n_err++;
      $display("FAIL rst_recover_sp: got lat=%0d res=%h want lat=3 res=40000000", lat, result2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_wide();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
